// File: rtl/replica_exchange_sequencer.sv
// Replica exchange sequencer.
// Runs the per-iteration schedule (request opt/delta, one SELF cycle, one
// PREV/FOLW exchange cycle) over the replica array, alternating even/odd
// neighbour pairs each iteration. All outputs come straight from flops.

package replica_pkg;
  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PREV = 2'd1,
    FOLW = 2'd2,
    SELF = 2'd3
  } exchange_command_t;
endpackage

module replica_exchange_sequencer
  import replica_pkg::*;
#(
  parameter int N_REPLICA = 32,
  parameter int ITER_W    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [ITER_W-1:0]                    n_iter,
  output logic                                 opt_req,
  input  logic                                 opt_ack,
  output logic                                 rnd_en,
  input  logic [N_REPLICA-2:0]                 ex_accept,
  output exchange_command_t [N_REPLICA-1:0]    cmd,
  output logic                                 busy,
  output logic                                 done,
  output logic [ITER_W-1:0]                    iter_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPT   = 3'd1,
    METRO = 3'd2,
    EXCH  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t                            state;
  state_t                            state_next;
  logic [ITER_W-1:0]                 n_iter_lat;
  logic [ITER_W-1:0]                 n_iter_lat_next;
  logic [ITER_W-1:0]                 iter_next;
  logic [ITER_W-1:0]                 iter_inc;
  exchange_command_t [N_REPLICA-1:0] pair_cmd;
  exchange_command_t [N_REPLICA-1:0] cmd_next;

  assign iter_inc = iter_cnt + {{(ITER_W-1){1'b0}}, 1'b1};

  // Exchange pattern for this iteration: pairs start on the replica whose index parity matches iter_cnt[0].
  always_comb begin
    for (int i = 0; i < N_REPLICA; i++) begin
      pair_cmd[i] = NOP;
    end
    for (int i = 0; i < N_REPLICA - 1; i++) begin
      if ((i[0] == iter_cnt[0]) && ex_accept[i]) begin
        pair_cmd[i]     = FOLW;
        pair_cmd[i + 1] = PREV;
      end
    end
  end

  // Next-state and iteration bookkeeping; abort in any active state drops back to IDLE with iter_cnt frozen.
  always_comb begin
    state_next      = state;
    iter_next       = iter_cnt;
    n_iter_lat_next = n_iter_lat;
    case (state)
      IDLE: begin
        if (start) begin
          n_iter_lat_next = n_iter;
          iter_next       = '0;
          state_next      = (n_iter == '0) ? FIN : OPT;
        end
      end
      OPT: begin
        if (opt_ack) begin
          state_next = METRO;
        end
      end
      METRO: begin
        state_next = EXCH;
      end
      EXCH: begin
        iter_next  = iter_inc;
        state_next = (iter_inc == n_iter_lat) ? FIN : OPT;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if ((state != IDLE) && abort) begin
      state_next = IDLE;
      iter_next  = iter_cnt;
    end
  end

  // Replica commands for the upcoming state; only METRO and EXCH ever issue anything but NOP.
  always_comb begin
    for (int i = 0; i < N_REPLICA; i++) begin
      cmd_next[i] = NOP;
    end
    case (state_next)
      METRO: begin
        for (int i = 0; i < N_REPLICA; i++) begin
          cmd_next[i] = SELF;
        end
      end
      EXCH: begin
        cmd_next = pair_cmd;
      end
      default: begin
      end
    endcase
  end

  // State register plus registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      n_iter_lat <= '0;
      iter_cnt   <= '0;
      opt_req    <= 1'b0;
      rnd_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < N_REPLICA; i++) begin
        cmd[i] <= NOP;
      end
    end else begin
      state      <= state_next;
      n_iter_lat <= n_iter_lat_next;
      iter_cnt   <= iter_next;
      opt_req    <= (state_next == OPT);
      rnd_en     <= (state_next == METRO);
      busy       <= (state_next != IDLE);
      done       <= (state_next == FIN);
      cmd        <= cmd_next;
    end
  end

endmodule

// File: tb/tb_replica_exchange_sequencer.sv
// Self-checking bench for replica_exchange_sequencer.
// Each run is described as a cycle-by-cycle expected trace built from the
// schedule rules, then replayed against the DUT with random noise on inputs
// that should be ignored.

module tb_replica_exchange_sequencer;
  import replica_pkg::*;

  localparam int N  = 4;
  localparam int IW = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic                       abort;
  logic [IW-1:0]              n_iter;
  logic                       opt_ack;
  logic [N-2:0]               ex_accept;
  logic                       opt_req;
  logic                       rnd_en;
  logic                       busy;
  logic                       done;
  logic [IW-1:0]              iter_cnt;
  exchange_command_t [N-1:0]  cmd;
  logic [2*N-1:0]             cmd_bits;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           opt_req;
    logic           rnd_en;
    logic           done;
    logic [IW-1:0]  iter;
    logic [2*N-1:0] cmd;
    logic           ack;
    logic [N-2:0]   acc;
  } cyc_t;

  cyc_t trace[$];

  assign cmd_bits = cmd;

  // Free-running clock.
  always #5 clk = ~clk;

  replica_exchange_sequencer #(
    .N_REPLICA (N),
    .ITER_W    (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .n_iter    (n_iter),
    .opt_req   (opt_req),
    .opt_ack   (opt_ack),
    .rnd_en    (rnd_en),
    .ex_accept (ex_accept),
    .cmd       (cmd),
    .busy      (busy),
    .done      (done),
    .iter_cnt  (iter_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] all_cmd(input exchange_command_t c);
    exchange_command_t [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = c;
    return e;
  endfunction

  function automatic logic [2*N-1:0] exch_cmd(input logic [N-2:0] acc, input int p);
    exchange_command_t [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = NOP;
    for (int i = p; i + 1 < N; i += 2) begin
      if (acc[i]) begin
        e[i]     = FOLW;
        e[i + 1] = PREV;
      end
    end
    return e;
  endfunction

  function automatic void push(input logic oreq, input logic rnd, input logic dn,
                               input logic [IW-1:0] it, input logic [2*N-1:0] c,
                               input logic ack, input logic [N-2:0] acc);
    cyc_t e;
    e.opt_req = oreq;
    e.rnd_en  = rnd;
    e.done    = dn;
    e.iter    = it;
    e.cmd     = c;
    e.ack     = ack;
    e.acc     = acc;
    trace.push_back(e);
  endfunction

  // fd / fa < 0 select a random opt_ack delay / random ex_accept per iteration.
  function automatic void build_trace(input int n, input int fd, input int fa);
    trace.delete();
    for (int k = 0; k < n; k++) begin
      int           d;
      logic [N-2:0] a;
      d = (fd < 0) ? int'($urandom_range(0, 3)) : fd;
      a = (fa < 0) ? (N-1)'($urandom) : (N-1)'(fa);
      for (int j = 0; j <= d; j++) begin
        push(1'b1, 1'b0, 1'b0, IW'(k), all_cmd(NOP), (j == d), (N-1)'($urandom));
      end
      push(1'b0, 1'b1, 1'b0, IW'(k), all_cmd(SELF), 1'($urandom % 2), a);
      push(1'b0, 1'b0, 1'b0, IW'(k), exch_cmd(a, k % 2), 1'($urandom % 2), (N-1)'($urandom));
    end
    push(1'b0, 1'b0, 1'b1, IW'(n), all_cmd(NOP), 1'($urandom % 2), (N-1)'($urandom));
  endfunction

  task automatic checkIdle(input string tag, input logic [IW-1:0] exp_iter);
    checkOutput({tag, ".opt_req"}, 32'(opt_req), 32'(0));
    checkOutput({tag, ".rnd_en"},  32'(rnd_en),  32'(0));
    checkOutput({tag, ".busy"},    32'(busy),    32'(0));
    checkOutput({tag, ".done"},    32'(done),    32'(0));
    checkOutput({tag, ".iter"},    32'(iter_cnt), 32'(exp_iter));
    checkOutput({tag, ".cmd"},     32'(cmd_bits), 32'(all_cmd(NOP)));
  endtask

  // kind: 0 = run to completion, 1 = abort at trace index stop_at, 2 = reset at stop_at.
  task automatic applyStimulus(input string name, input int n, input int stop_at, input int kind);
    logic [IW-1:0] final_iter;
    final_iter = IW'(n);
    start  = 1'b1;
    n_iter = IW'(n);
    @(posedge clk); #1;
    for (int idx = 0; idx < trace.size(); idx++) begin
      string t;
      t = $sformatf("%s[%0d]", name, idx);
      checkOutput({t, ".opt_req"}, 32'(opt_req),  32'(trace[idx].opt_req));
      checkOutput({t, ".rnd_en"},  32'(rnd_en),   32'(trace[idx].rnd_en));
      checkOutput({t, ".busy"},    32'(busy),     32'(1));
      checkOutput({t, ".done"},    32'(done),     32'(trace[idx].done));
      checkOutput({t, ".iter"},    32'(iter_cnt), 32'(trace[idx].iter));
      checkOutput({t, ".cmd"},     32'(cmd_bits), 32'(trace[idx].cmd));
      opt_ack   = trace[idx].ack;
      ex_accept = trace[idx].acc;
      start     = 1'($urandom % 2);
      n_iter    = IW'($urandom);
      abort     = (kind == 1) && (idx == stop_at);
      reset     = !((kind == 2) && (idx == stop_at));
      if (idx == stop_at) final_iter = (kind == 2) ? '0 : trace[idx].iter;
      @(posedge clk); #1;
      abort = 1'b0;
      reset = 1'b1;
      if (idx == stop_at) break;
    end
    start = 1'b0;
    checkIdle({name, ".end"}, final_iter);
    @(posedge clk); #1;
    checkIdle({name, ".idle"}, final_iter);
  endtask

  // Directed scenarios followed by randomized runs.
  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    opt_ack   = 1'b0;
    ex_accept = '0;
    n_iter    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset", '0);
    reset = 1'b1;

    build_trace(2, 0, 7);
    applyStimulus("all_accept", 2, -1, 0);

    build_trace(2, 0, 2);
    applyStimulus("mid_accept", 2, -1, 0);

    build_trace(1, 5, -1);
    applyStimulus("ack_delay5", 1, -1, 0);

    build_trace(10, 1, -1);
    applyStimulus("abort_opt3", 10, 12, 1);
    build_trace(2, -1, -1);
    applyStimulus("restart", 2, -1, 0);

    build_trace(2, 0, 7);
    applyStimulus("reset_exch", 2, 2, 2);

    build_trace(0, 0, 0);
    applyStimulus("zero_iter", 0, -1, 0);

    build_trace(15, 0, -1);
    applyStimulus("max_iter", 15, -1, 0);

    for (int r = 0; r < 12; r++) begin
      int n;
      int kind;
      int stop;
      n = int'($urandom_range(0, 5));
      build_trace(n, -1, -1);
      kind = int'($urandom_range(0, 2));
      stop = (kind == 0) ? -1 : int'($urandom_range(0, trace.size() - 1));
      applyStimulus($sformatf("rand%0d", r), n, stop, kind);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
